// File: rtl/crab_mmio_pkg.sv
// crab_mmio_pkg: shared register map, status bit positions and transmitter states for MMIO peripherals.
package crab_mmio_pkg;
   localparam logic [3:0] REG_TXDATA  = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_BAUDDIV = 4'h8;
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous 8-bit FIFO; a push into a full FIFO is accepted only alongside a pop.
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;
   assign empty   = cnt == '0;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp];
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= wp + AW'(do_push);
         rp  <= rp + AW'(do_pop);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO, baud divisor and sticky overflow flag.
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        irq
);
   import crab_mmio_pkg::*;
   tx_state_e   state;
   logic [1:0]  sel;
   logic        wr, push, pop, full, empty, busy, ovf, tick;
   logic [7:0]  head, sh;
   logic [2:0]  bit_idx;
   logic [15:0] baud, div_q, cnt;
   logic [31:0] status, rd_val;
   logic        unused_ok;
   assign unused_ok = ^{addr[1:0], wdata[31:16]};
   assign sel  = addr[3:2];
   assign wr   = req && we;
   assign push = wr && sel == REG_TXDATA[3:2];
   assign busy = state != TX_IDLE;
   assign irq  = empty && !busy;
   assign tick = cnt == div_q - 16'd1;
   // Popping at the end of a stop bit chains frames with no idle gap.
   assign pop  = !empty && (state == TX_IDLE || (state == TX_STOP && tick));
   assign tx   = state == TX_START ? 1'b0 : state == TX_DATA ? sh[0] : 1'b1;
   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .din(wdata[7:0]),
      .pop(pop), .dout(head), .full(full), .empty(empty)
   );
   always_comb begin
      status           = '0;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_BUSY]  = busy;
      status[ST_OVF]   = ovf;
      rd_val = sel == REG_STATUS[3:2]  ? status :
               sel == REG_BAUDDIV[3:2] ? {16'd0, baud} : '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done  <= 1'b0;
         rdata <= '0;
         baud  <= DIV_RESET;
         ovf   <= 1'b0;
      end else begin
         done  <= req;
         rdata <= (req && !we) ? rd_val : '0;
         if (wr && sel == REG_BAUDDIV[3:2]) baud <= wdata[15:0] == '0 ? 16'd1 : wdata[15:0];
         if (push && full && !pop) ovf <= 1'b1;
         else if (wr && sel == REG_STATUS[3:2] && wdata[ST_OVF]) ovf <= 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= TX_IDLE;
         sh      <= '0;
         div_q   <= DIV_RESET;
         cnt     <= '0;
         bit_idx <= '0;
      end else if (pop) begin
         state <= TX_START;
         sh    <= head;
         div_q <= baud;
         cnt   <= '0;
      end else if (busy) begin
         cnt <= tick ? '0 : cnt + 16'd1;
         if (tick) begin
            case (state)
               TX_START: begin
                  state   <= TX_DATA;
                  bit_idx <= '0;
               end
               TX_DATA: begin
                  sh      <= sh >> 1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= TX_STOP;
               end
               TX_STOP: state <= TX_IDLE;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: table-driven register checks plus directed frame, overflow and reset sequences.
module tb_mmio_uart_tx;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        done, tx, irq;
   logic [31:0] rdata;
   int checks = 0;
   int failures = 0;
   int falls = 0;
   logic tx_d = 1'b1;

   mmio_uart_tx dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .done(done), .rdata(rdata), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_d && !tx) falls <= falls + 1;
      tx_d <= tx;
   end

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] rd);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      chk("done_pulse", {31'd0, done}, 32'd1);
      rd = rdata;
   endtask

   task automatic check_frame(input logic [7:0] b, input int div);
      logic e;
      for (int k = 0; k < 10 * div; k++) begin
         e = (k / div == 0) ? 1'b0 : (k / div == 9) ? 1'b1 : b[k / div - 1];
         chk("frame_bit", {31'd0, tx}, {31'd0, e});
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] rd;
      int f0;
      bit seen;
      vt[0]  = '{1'b0, 4'h4, 32'h0, 32'h2};
      vt[1]  = '{1'b0, 4'h8, 32'h0, 32'd434};
      vt[2]  = '{1'b0, 4'h0, 32'h0, 32'h0};
      vt[3]  = '{1'b0, 4'hC, 32'h0, 32'h0};
      vt[4]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
      vt[5]  = '{1'b0, 4'hC, 32'h0, 32'h0};
      vt[6]  = '{1'b1, 4'h8, 32'h0001_2345, 32'h0};
      vt[7]  = '{1'b0, 4'h9, 32'h0, 32'h2345};
      vt[8]  = '{1'b1, 4'h8, 32'h0, 32'h0};
      vt[9]  = '{1'b0, 4'h8, 32'h0, 32'h1};
      vt[10] = '{1'b1, 4'h4, 32'hF, 32'h0};
      vt[11] = '{1'b0, 4'h4, 32'h0, 32'h2};
      #12 reset = 1'b1;
      @(posedge clk); #1;
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_irq", {31'd0, irq}, 32'd1);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      for (int i = 0; i < 12; i++) begin
         acc(vt[i].we, vt[i].addr, vt[i].wdata, rd);
         chk($sformatf("vec%0d", i), rd, vt[i].exp);
      end
      @(posedge clk); #1;
      chk("done_low", {31'd0, done}, 32'd0);
      chk("rdata_idle", rdata, 32'd0);

      // single frame at divisor 4
      acc(1'b1, 4'h8, 32'd4, rd);
      acc(1'b1, 4'h0, 32'h55, rd);
      chk("tx_before_fall", {31'd0, tx}, 32'd1);
      @(posedge clk); #1;
      check_frame(8'h55, 4);
      chk("idle_after_55", {31'd0, irq}, 32'd1);

      // three contiguous frames at divisor 2
      acc(1'b1, 4'h8, 32'd2, rd);
      acc(1'b1, 4'h0, 32'hA1, rd);
      fork
         begin
            acc(1'b1, 4'h0, 32'hB2, rd);
            acc(1'b1, 4'h0, 32'hC3, rd);
         end
         begin
            @(posedge clk); #1;
            check_frame(8'hA1, 2);
            check_frame(8'hB2, 2);
            check_frame(8'hC3, 2);
         end
      join
      chk("idle_after_3", {31'd0, irq}, 32'd1);

      // divisor change mid-frame only affects the next frame
      acc(1'b1, 4'h8, 32'd4, rd);
      acc(1'b1, 4'h0, 32'h0F, rd);
      fork
         begin
            acc(1'b1, 4'h0, 32'h96, rd);
            acc(1'b1, 4'h8, 32'd8, rd);
         end
         begin
            @(posedge clk); #1;
            check_frame(8'h0F, 4);
            check_frame(8'h96, 8);
         end
      join
      chk("idle_after_div", {31'd0, irq}, 32'd1);

      // overflow: 10 writes, 9 accepted
      acc(1'b1, 4'h8, 32'd100, rd);
      f0 = falls;
      for (int i = 0; i < 10; i++) acc(1'b1, 4'h0, 32'hFF, rd);
      acc(1'b0, 4'h4, 32'h0, rd);
      chk("status_ovf", rd, 32'hD);
      acc(1'b1, 4'h4, 32'h8, rd);
      acc(1'b0, 4'h4, 32'h0, rd);
      chk("status_ovf_clr", rd, 32'h5);
      acc(1'b1, 4'h8, 32'd1, rd);
      seen = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(posedge clk); #1;
         seen = irq;
      end
      chk("ovf_drain_timeout", {31'd0, seen}, 32'd1);
      @(negedge clk); #1;
      chk("ovf_frames", falls - f0, 32'd9);

      // reset during DATA
      acc(1'b1, 4'h8, 32'd4, rd);
      acc(1'b1, 4'h0, 32'h00, rd);
      acc(1'b1, 4'h0, 32'h00, rd);
      repeat (7) begin @(posedge clk); #1; end
      chk("tx_in_data", {31'd0, tx}, 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("tx_async_reset", {31'd0, tx}, 32'd1);
      chk("irq_async_reset", {31'd0, irq}, 32'd1);
      #3 reset = 1'b1;
      @(posedge clk); #1;
      acc(1'b0, 4'h4, 32'h0, rd);
      chk("status_after_reset", rd, 32'h2);
      for (int i = 0; i < 60; i++) begin
         chk("tx_quiet", {31'd0, tx}, 32'd1);
         @(posedge clk); #1;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped 8N1 UART transmitter that sits directly downstream of the memory bus controller as a peripheral slave in the 0xFFFFFFxx I/O window. The bus controller decodes the I/O region and forwards register accesses here; the block buffers bytes in a small FIFO and serialises them on a single `tx` pin. It gives the core a console output alongside the seven-segment hex register.

## Interface
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, ≥2.
- `DIV_RESET`, 434: reset value of BAUDDIV (115200 baud at 50 MHz).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: single-cycle register access strobe from the bus controller.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in 4: byte offset within the block; bits [1:0] ignored.
- `wdata` in 32: write data; sampled with `req`.
- `done` out 1: one-cycle access-complete pulse.
- `rdata` out 32: read data, valid while `done` = 1, otherwise 0.
- `tx` out 1: serial output, idle high.
- `irq` out 1: level; high while FIFO empty and transmitter idle.

## Operation
- Registers:
  - 0x0 TXDATA (W): push `wdata[7:0]`. Read returns 0.
  - 0x4 STATUS (R): bit0 full, bit1 empty, bit2 busy (shifter active), bit3 overflow (sticky). Writing 1 to bit3 clears it; other bits are read-only.
  - 0x8 BAUDDIV (R/W): bits [15:0] give cycles per bit. A write of 0 stores 1. Upper bits read as 0.
  - 0xC reserved: reads 0, writes ignored.
- Write to TXDATA while full with no pop in the same cycle: byte dropped, overflow set. A push and pop in the same cycle on a full FIFO is accepted; the count stays at `FIFO_DEPTH`.
- Transmitter FSM states:
  - IDLE: `tx` = 1. Go to START when the FIFO is non-empty: pop the head into the shift register and latch BAUDDIV into the bit divisor.
  - START: `tx` = 0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, then STOP.
  - STOP: `tx` = 1 for one bit period. Then START if the FIFO is non-empty (pop and relatch, no idle gap); otherwise IDLE.
- Bit period = latched divisor cycles; one frame = 10 bit periods. A BAUDDIV write mid-frame affects only the next frame.
- busy = state ≠ IDLE. irq = empty && !busy.

## Timing
- Reset values: `tx` = 1, `done` = 0, `rdata` = 0, `irq` = 1. FIFO empty, overflow 0, BAUDDIV = `DIV_RESET`, FSM in IDLE.
- `done` pulses exactly one cycle after every `req`, read or write, including reserved offsets. A new `req` is legal on every cycle.
- Read data reflects state as of the `req` cycle, before that cycle's updates.
- A TXDATA write at cycle N into an empty FIFO with the FSM in IDLE: pop at N+1, `tx` falls at N+2.
- Back-to-back frames: after the last stop-bit cycle, the next start bit begins on the following cycle.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronously), the FIFO is flushed, and the partial frame is lost.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap. The count is one bit wider so full and empty are distinguished.

## Structure
- Shared package `crab_mmio_pkg` holds:
  - register offset constants (TXDATA, STATUS, BAUDDIV);
  - STATUS bit indices;
  - the transmitter state enum (IDLE, START, DATA, STOP).
- Sub-module `byte_fifo`: synchronous FIFO (8-bit data, `FIFO_DEPTH`) with `push`/`pop`/`full`/`empty` and asynchronous active-low reset. It is reusable for a later UART receiver.

## Test plan
- Reset, then read STATUS and BAUDDIV -> STATUS = 0x2, BAUDDIV = 434, `tx` = 1, `irq` = 1.
- BAUDDIV = 4, write 0x55 -> `tx` falls 2 cycles after `req`; waveform 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles; then IDLE, `irq` = 1.
- BAUDDIV = 2, three consecutive-cycle writes 0xA1, 0xB2, 0xC3 -> three frames of 20 cycles each, contiguous, with no idle cycle between stop and start.
- BAUDDIV = 100, write 10 bytes in 10 cycles -> 9 accepted (1 popped + 8 buffered), the 10th dropped; STATUS bit3 = 1. Write 0x8 to STATUS -> bit3 = 0.
- Write BAUDDIV = 0 -> reads back 1. Change BAUDDIV from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits and the next frame uses 8.
- Assert reset during the DATA state -> `tx` = 1 in the same cycle; after release, STATUS = 0x2 and no further frame is sent.
